// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: entry type encodings and datapath widths.
package reorder_buffer_pkg;

    localparam int ROB_TYPE_W = 2;
    localparam int DATA_W     = 32;
    localparam int REG_ID_W   = 5;

    typedef logic [ROB_TYPE_W-1:0] rob_type_t;

    // Entry kinds decide what happens when the entry reaches the head.
    localparam rob_type_t ROB_REG    = 2'd0;
    localparam rob_type_t ROB_STORE  = 2'd1;
    localparam rob_type_t ROB_BRANCH = 2'd2;
    localparam rob_type_t ROB_EXIT   = 2'd3;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at tail, captures ALU/LSB broadcasts,
// retires one entry per cycle in program order and raises a one-cycle flush
// on branch mispredicts. Retire-side outputs are registered.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_BIT = 3
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                issue_valid,
    input  logic [ROB_TYPE_W-1:0] issue_type,
    input  logic [REG_ID_W-1:0] issue_rd,
    input  logic [DATA_W-1:0]   issue_pc,
    input  logic                issue_pred_taken,
    input  logic [DATA_W-1:0]   issue_alt_pc,
    input  logic                issue_ready,
    input  logic [DATA_W-1:0]   issue_value,
    output logic [ROB_BIT-1:0]  rob_tail,
    output logic                rob_full,
    input  logic                alu_valid,
    input  logic [ROB_BIT-1:0]  alu_entry,
    input  logic [DATA_W-1:0]   alu_value,
    input  logic                alu_taken,
    input  logic                lsb_valid,
    input  logic [ROB_BIT-1:0]  lsb_entry,
    input  logic [DATA_W-1:0]   lsb_value,
    input  logic [ROB_BIT-1:0]  get_rob_entry1,
    input  logic [ROB_BIT-1:0]  get_rob_entry2,
    output logic                ready1,
    output logic                ready2,
    output logic [DATA_W-1:0]   value1,
    output logic [DATA_W-1:0]   value2,
    output logic                rob_commit,
    output logic [REG_ID_W-1:0] commit_reg_id,
    output logic [DATA_W-1:0]   commit_reg_data,
    output logic [ROB_BIT-1:0]  commit_rob_entry,
    output logic                commit_store,
    output logic                rob_clear_up,
    output logic [DATA_W-1:0]   clear_pc,
    output logic                rob_exit
);

    localparam int ENTRIES = 2 ** ROB_BIT;
    localparam logic [ROB_BIT:0] FULL_COUNT = (ROB_BIT + 1)'(ENTRIES);

    // Queue pointers; count disambiguates head == tail (empty vs full).
    logic [ROB_BIT-1:0] head_r;
    logic [ROB_BIT-1:0] tail_r;
    logic [ROB_BIT:0]   count_r;

    // Per-entry state.
    logic [ENTRIES-1:0]  busy_r;
    logic [ENTRIES-1:0]  ready_r;
    logic [ENTRIES-1:0]  pred_r;
    logic [ENTRIES-1:0]  taken_r;
    rob_type_t           type_r   [ENTRIES];
    logic [REG_ID_W-1:0] rd_r     [ENTRIES];
    logic [DATA_W-1:0]   value_r  [ENTRIES];
    logic [DATA_W-1:0]   alt_pc_r [ENTRIES];

    // Registered retire-side outputs.
    logic                rob_commit_r;
    logic [REG_ID_W-1:0] commit_reg_id_r;
    logic [DATA_W-1:0]   commit_reg_data_r;
    logic [ROB_BIT-1:0]  commit_rob_entry_r;
    logic                commit_store_r;
    logic                clear_up_r;
    logic [DATA_W-1:0]   clear_pc_r;
    logic                exit_r;

    logic       full_s;
    logic       issue_acc_s;
    logic       retire_s;
    logic       mispredict_s;
    rob_type_t  head_type_s;
    logic [DATA_W:0] lookup1_s;
    logic [DATA_W:0] lookup2_s;

    // The instruction PC is not needed at retire (the redirect target is
    // alt_pc), so it is only folded into a sink to show it is consumed.
    logic unused_pc_s;
    assign unused_pc_s = ^issue_pc;

    // Operand lookup: a same-cycle broadcast wins over the stored entry.
    function automatic logic [DATA_W:0] lookup(input logic [ROB_BIT-1:0] idx);
        logic [DATA_W:0] res;
        if (alu_valid && (alu_entry == idx)) begin
            res = {1'b1, alu_value};
        end else if (lsb_valid && (lsb_entry == idx)) begin
            res = {1'b1, lsb_value};
        end else begin
            res = {ready_r[idx], value_r[idx]};
        end
        return res;
    endfunction

    // Issue acceptance and retire decision from the registered state.
    always_comb begin
        full_s       = (count_r == FULL_COUNT);
        head_type_s  = type_r[head_r];
        issue_acc_s  = issue_valid && !full_s && !clear_up_r;
        retire_s     = busy_r[head_r] && ready_r[head_r] && !exit_r && !clear_up_r;
        mispredict_s = (head_type_s == ROB_BRANCH) && (taken_r[head_r] != pred_r[head_r]);
    end

    // Combinational operand lookups for the register file.
    always_comb begin
        lookup1_s = lookup(get_rob_entry1);
        lookup2_s = lookup(get_rob_entry2);
    end

    assign ready1           = lookup1_s[DATA_W];
    assign value1           = lookup1_s[DATA_W-1:0];
    assign ready2           = lookup2_s[DATA_W];
    assign value2           = lookup2_s[DATA_W-1:0];
    assign rob_tail         = tail_r;
    assign rob_full         = full_s;
    assign rob_commit       = rob_commit_r;
    assign commit_reg_id    = commit_reg_id_r;
    assign commit_reg_data  = commit_reg_data_r;
    assign commit_rob_entry = commit_rob_entry_r;
    assign commit_store     = commit_store_r;
    assign rob_clear_up     = clear_up_r;
    assign clear_pc         = clear_pc_r;
    assign rob_exit         = exit_r;

    // Allocation, writeback capture, in-order retire and flush handling.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_r             <= '0;
            tail_r             <= '0;
            count_r            <= '0;
            busy_r             <= '0;
            ready_r            <= '0;
            pred_r             <= '0;
            taken_r            <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                type_r[i]   <= ROB_REG;
                rd_r[i]     <= 5'd0;
                value_r[i]  <= 32'd0;
                alt_pc_r[i] <= 32'd0;
            end
            rob_commit_r       <= 1'b0;
            commit_reg_id_r    <= 5'd0;
            commit_reg_data_r  <= 32'd0;
            commit_rob_entry_r <= '0;
            commit_store_r     <= 1'b0;
            clear_up_r         <= 1'b0;
            clear_pc_r         <= 32'd0;
            exit_r             <= 1'b0;
        end else if (rdy_in) begin
            if (clear_up_r) begin
                // Flush cycle: everything in flight is discarded.
                head_r         <= '0;
                tail_r         <= '0;
                count_r        <= '0;
                busy_r         <= '0;
                ready_r        <= '0;
                clear_up_r     <= 1'b0;
                rob_commit_r   <= 1'b0;
                commit_store_r <= 1'b0;
            end else begin
                rob_commit_r   <= 1'b0;
                commit_store_r <= 1'b0;

                if (issue_acc_s) begin
                    busy_r[tail_r]   <= 1'b1;
                    ready_r[tail_r]  <= issue_ready;
                    pred_r[tail_r]   <= issue_pred_taken;
                    taken_r[tail_r]  <= 1'b0;
                    type_r[tail_r]   <= issue_type;
                    rd_r[tail_r]     <= issue_rd;
                    value_r[tail_r]  <= issue_value;
                    alt_pc_r[tail_r] <= issue_alt_pc;
                    tail_r           <= tail_r + 1'b1;
                end

                // Broadcasts to free entries are stale and dropped.
                if (alu_valid && busy_r[alu_entry]) begin
                    ready_r[alu_entry] <= 1'b1;
                    value_r[alu_entry] <= alu_value;
                    taken_r[alu_entry] <= alu_taken;
                end
                if (lsb_valid && busy_r[lsb_entry]) begin
                    ready_r[lsb_entry] <= 1'b1;
                    value_r[lsb_entry] <= lsb_value;
                end

                if (retire_s) begin
                    busy_r[head_r]  <= 1'b0;
                    ready_r[head_r] <= 1'b0;
                    head_r          <= head_r + 1'b1;
                    case (head_type_s)
                        ROB_REG: begin
                            rob_commit_r       <= 1'b1;
                            commit_reg_id_r    <= rd_r[head_r];
                            commit_reg_data_r  <= value_r[head_r];
                            commit_rob_entry_r <= head_r;
                        end
                        ROB_STORE: begin
                            commit_store_r <= 1'b1;
                        end
                        ROB_BRANCH: begin
                            if (mispredict_s) begin
                                clear_up_r <= 1'b1;
                                clear_pc_r <= alt_pc_r[head_r];
                            end
                        end
                        ROB_EXIT: begin
                            exit_r <= 1'b1;
                        end
                        default: begin
                            exit_r <= exit_r;
                        end
                    endcase
                end

                case ({issue_acc_s, retire_s})
                    2'b10:   count_r <= count_r + 1'b1;
                    2'b01:   count_r <= count_r - 1'b1;
                    default: count_r <= count_r;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: per-scenario tasks plus a commit
// scoreboard filled at issue time and drained on each fresh rob_commit pulse.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int ROB_BIT = 3;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;
    logic issue_valid = 1'b0;
    logic [1:0] issue_type = 2'd0;
    logic [4:0] issue_rd = 5'd0;
    logic [31:0] issue_pc = 32'd0;
    logic issue_pred_taken = 1'b0;
    logic [31:0] issue_alt_pc = 32'd0;
    logic issue_ready = 1'b0;
    logic [31:0] issue_value = 32'd0;
    logic [ROB_BIT-1:0] rob_tail;
    logic rob_full;
    logic alu_valid = 1'b0;
    logic [ROB_BIT-1:0] alu_entry = 3'd0;
    logic [31:0] alu_value = 32'd0;
    logic alu_taken = 1'b0;
    logic lsb_valid = 1'b0;
    logic [ROB_BIT-1:0] lsb_entry = 3'd0;
    logic [31:0] lsb_value = 32'd0;
    logic [ROB_BIT-1:0] get_rob_entry1 = 3'd0;
    logic [ROB_BIT-1:0] get_rob_entry2 = 3'd0;
    logic ready1, ready2;
    logic [31:0] value1, value2;
    logic rob_commit;
    logic [4:0] commit_reg_id;
    logic [31:0] commit_reg_data;
    logic [ROB_BIT-1:0] commit_rob_entry;
    logic commit_store;
    logic rob_clear_up;
    logic [31:0] clear_pc;
    logic rob_exit;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [2:0]  entry;
    } exp_t;
    exp_t sb_q[$];
    logic edge_live = 1'b0;

    reorder_buffer #(.ROB_BIT(ROB_BIT)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
        .issue_alt_pc(issue_alt_pc), .issue_ready(issue_ready), .issue_value(issue_value),
        .rob_tail(rob_tail), .rob_full(rob_full),
        .alu_valid(alu_valid), .alu_entry(alu_entry), .alu_value(alu_value), .alu_taken(alu_taken),
        .lsb_valid(lsb_valid), .lsb_entry(lsb_entry), .lsb_value(lsb_value),
        .get_rob_entry1(get_rob_entry1), .get_rob_entry2(get_rob_entry2),
        .ready1(ready1), .ready2(ready2), .value1(value1), .value2(value2),
        .rob_commit(rob_commit), .commit_reg_id(commit_reg_id),
        .commit_reg_data(commit_reg_data), .commit_rob_entry(commit_rob_entry),
        .commit_store(commit_store), .rob_clear_up(rob_clear_up),
        .clear_pc(clear_pc), .rob_exit(rob_exit)
    );

    always #5 clk_in = ~clk_in;

    // Remember whether the last edge could update the DUT (held pulses are not new).
    always @(posedge clk_in) edge_live <= rdy_in && !rst_in;

    // Scoreboard: every fresh commit pulse must match the oldest expected commit.
    always @(negedge clk_in) begin
        if (edge_live && rob_commit) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_commit: got id=%0d entry=%0d, expected no commit",
                         commit_reg_id, commit_rob_entry);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checks++;
                if ({commit_reg_id, commit_reg_data, commit_rob_entry} !== {e.rd, e.data, e.entry}) begin
                    errors++;
                    $display("FAIL sb_commit: got id=%0d data=%h entry=%0d, expected id=%0d data=%h entry=%0d",
                             commit_reg_id, commit_reg_data, commit_rob_entry, e.rd, e.data, e.entry);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        alu_valid   = 1'b0;
        lsb_valid   = 1'b0;
        alu_taken   = 1'b0;
    endtask

    task automatic set_issue(input rob_type_t t, input logic [4:0] rd, input logic rdy,
                             input logic [31:0] v, input logic pred, input logic [31:0] alt);
        issue_valid      = 1'b1;
        issue_type       = t;
        issue_rd         = rd;
        issue_ready      = rdy;
        issue_value      = v;
        issue_pred_taken = pred;
        issue_alt_pc     = alt;
        issue_pc         = alt - 32'd4;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst_in = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        idle_inputs();
        get_rob_entry1 = 3'd0;
        get_rob_entry2 = 3'd5;
        tick();
        tick();
        checks++;
        if ({rob_full, rob_commit, commit_store, rob_clear_up, rob_exit, ready1, ready2} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 0000000",
                     {rob_full, rob_commit, commit_store, rob_clear_up, rob_exit, ready1, ready2});
        end
        checks++;
        if ({rob_tail, clear_pc, commit_reg_data, commit_reg_id} !== 43'd0) begin
            errors++;
            $display("FAIL reset_values: got tail=%0d clear_pc=%h data=%h id=%0d, expected all 0",
                     rob_tail, clear_pc, commit_reg_data, commit_reg_id);
        end
        rst_in = 1'b0;
    endtask

    task automatic test_basic_commit();
        do_reset();
        set_issue(ROB_REG, 5'd5, 1'b1, 32'h11, 1'b0, 32'd0);
        sb_q.push_back('{rd: 5'd5, data: 32'h11, entry: 3'd0});
        tick();
        idle_inputs();
        checks++;
        if (rob_commit !== 1'b0) begin
            errors++;
            $display("FAIL basic_early: got rob_commit=%b, expected 0", rob_commit);
        end
        tick();
        checks++;
        if ({rob_commit, commit_reg_id, commit_reg_data, commit_rob_entry} !== {1'b1, 5'd5, 32'h11, 3'd0}) begin
            errors++;
            $display("FAIL basic_commit: got c=%b id=%0d data=%h entry=%0d, expected c=1 id=5 data=11 entry=0",
                     rob_commit, commit_reg_id, commit_reg_data, commit_rob_entry);
        end
        tick();
        checks++;
        if (rob_commit !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse_width: got rob_commit=%b, expected 0", rob_commit);
        end
    endtask

    task automatic test_full_and_bypass();
        int wait_n;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_issue(ROB_REG, 5'(i + 1), 1'b0, 32'd0, 1'b0, 32'd0);
            sb_q.push_back('{rd: 5'(i + 1), data: 32'(i + 5), entry: 3'(i)});
            tick();
        end
        checks++;
        if ({rob_full, rob_tail} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL full_after_8: got full=%b tail=%0d, expected full=1 tail=0", rob_full, rob_tail);
        end
        set_issue(ROB_REG, 5'd31, 1'b1, 32'hdead, 1'b0, 32'd0);
        tick();
        idle_inputs();
        checks++;
        if ({rob_full, rob_tail} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL full_ninth_ignored: got full=%b tail=%0d, expected full=1 tail=0", rob_full, rob_tail);
        end
        get_rob_entry1 = 3'd2;
        #1;
        checks++;
        if (ready1 !== 1'b0) begin
            errors++;
            $display("FAIL lookup_not_ready: got ready1=%b, expected 0", ready1);
        end
        for (int k = 0; k < 4; k++) begin
            alu_valid      = 1'b1;
            alu_entry      = 3'(2 * k);
            alu_value      = 32'(2 * k + 5);
            lsb_valid      = 1'b1;
            lsb_entry      = 3'(2 * k + 1);
            lsb_value      = 32'(2 * k + 6);
            get_rob_entry1 = 3'(2 * k);
            get_rob_entry2 = 3'(2 * k + 1);
            #1;
            checks++;
            if ({ready1, value1, ready2, value2} !== {1'b1, 32'(2 * k + 5), 1'b1, 32'(2 * k + 6)}) begin
                errors++;
                $display("FAIL lookup_bypass k=%0d: got r1=%b v1=%h r2=%b v2=%h, expected 1/%h 1/%h",
                         k, ready1, value1, ready2, value2, 32'(2 * k + 5), 32'(2 * k + 6));
            end
            tick();
        end
        idle_inputs();
        wait_n = 0;
        while (sb_q.size() != 0 && wait_n < 40) begin
            tick();
            wait_n++;
        end
        tick();
        checks++;
        if (sb_q.size() != 0 || rob_full !== 1'b0) begin
            errors++;
            $display("FAIL full_drain: got pending=%0d full=%b, expected pending=0 full=0", sb_q.size(), rob_full);
        end
    endtask

    task automatic test_branch();
        logic seen;
        int   clears;
        do_reset();
        set_issue(ROB_BRANCH, 5'd0, 1'b0, 32'd0, 1'b0, 32'h100);
        tick();
        set_issue(ROB_REG, 5'd4, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        idle_inputs();
        alu_valid = 1'b1;
        alu_entry = 3'd0;
        alu_value = 32'd0;
        alu_taken = 1'b1;
        tick();
        idle_inputs();
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            if (rob_clear_up === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++;
        if ({seen, clear_pc} !== {1'b1, 32'h100}) begin
            errors++;
            $display("FAIL branch_flush: got seen=%b clear_pc=%h, expected seen=1 clear_pc=00000100", seen, clear_pc);
        end
        set_issue(ROB_REG, 5'd6, 1'b1, 32'h66, 1'b0, 32'd0);
        alu_valid = 1'b1;
        alu_entry = 3'd1;
        tick();
        idle_inputs();
        checks++;
        if ({rob_clear_up, rob_full, rob_tail} !== {1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL branch_after_flush: got clr=%b full=%b tail=%0d, expected clr=0 full=0 tail=0",
                     rob_clear_up, rob_full, rob_tail);
        end
        set_issue(ROB_BRANCH, 5'd0, 1'b0, 32'd0, 1'b1, 32'h200);
        tick();
        set_issue(ROB_REG, 5'd9, 1'b1, 32'h99, 1'b0, 32'd0);
        sb_q.push_back('{rd: 5'd9, data: 32'h99, entry: 3'd1});
        tick();
        idle_inputs();
        alu_valid = 1'b1;
        alu_entry = 3'd0;
        alu_taken = 1'b1;
        tick();
        idle_inputs();
        clears = 0;
        for (int n = 0; n < 6; n++) begin
            if (rob_clear_up === 1'b1) clears++;
            tick();
        end
        checks++;
        if (clears != 0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL branch_correct: got clears=%0d pending=%0d, expected 0 and 0", clears, sb_q.size());
        end
    endtask

    task automatic test_store_exit();
        int stores;
        int commits;
        do_reset();
        set_issue(ROB_STORE, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        set_issue(ROB_EXIT, 5'd0, 1'b1, 32'd0, 1'b0, 32'd0);
        tick();
        set_issue(ROB_REG, 5'd3, 1'b1, 32'h33, 1'b0, 32'd0);
        tick();
        idle_inputs();
        lsb_valid = 1'b1;
        lsb_entry = 3'd0;
        lsb_value = 32'h40;
        tick();
        idle_inputs();
        stores  = 0;
        commits = 0;
        for (int n = 0; n < 8; n++) begin
            if (commit_store === 1'b1) stores++;
            if (rob_commit === 1'b1) commits++;
            tick();
        end
        checks++;
        if ({stores, commits} !== {32'd1, 32'd0}) begin
            errors++;
            $display("FAIL store_exit_pulses: got stores=%0d commits=%0d, expected 1 and 0", stores, commits);
        end
        checks++;
        if (rob_exit !== 1'b1) begin
            errors++;
            $display("FAIL exit_sticky: got rob_exit=%b, expected 1", rob_exit);
        end
        do_reset();
        checks++;
        if (rob_exit !== 1'b0) begin
            errors++;
            $display("FAIL exit_reset: got rob_exit=%b, expected 0", rob_exit);
        end
    endtask

    task automatic test_rdy_hold();
        do_reset();
        set_issue(ROB_REG, 5'd7, 1'b1, 32'h77, 1'b0, 32'd0);
        sb_q.push_back('{rd: 5'd7, data: 32'h77, entry: 3'd0});
        tick();
        idle_inputs();
        rdy_in = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (rob_commit !== 1'b0) begin
                errors++;
                $display("FAIL rdy_stall_cycle%0d: got rob_commit=%b, expected 0", n, rob_commit);
            end
        end
        rdy_in = 1'b1;
        tick();
        checks++;
        if ({rob_commit, commit_reg_id} !== {1'b1, 5'd7}) begin
            errors++;
            $display("FAIL rdy_resume: got c=%b id=%0d, expected c=1 id=7", rob_commit, commit_reg_id);
        end
        tick();
        checks++;
        if (rob_commit !== 1'b0) begin
            errors++;
            $display("FAIL rdy_single_pulse: got rob_commit=%b, expected 0", rob_commit);
        end
        set_issue(ROB_REG, 5'd8, 1'b1, 32'h88, 1'b0, 32'd0);
        sb_q.push_back('{rd: 5'd8, data: 32'h88, entry: 3'd1});
        tick();
        idle_inputs();
        tick();
        rdy_in = 1'b0;
        for (int n = 0; n < 2; n++) begin
            tick();
            checks++;
            if ({rob_commit, commit_reg_data} !== {1'b1, 32'h88}) begin
                errors++;
                $display("FAIL rdy_pulse_held%0d: got c=%b data=%h, expected c=1 data=00000088",
                         n, rob_commit, commit_reg_data);
            end
        end
        rdy_in = 1'b1;
        tick();
        checks++;
        if (rob_commit !== 1'b0) begin
            errors++;
            $display("FAIL rdy_held_release: got rob_commit=%b, expected 0", rob_commit);
        end
    endtask

    task automatic test_back_to_back();
        int  n_commit;
        int  gaps;
        logic started;
        do_reset();
        n_commit = 0;
        gaps     = 0;
        started  = 1'b0;
        for (int cyc = 0; cyc < 28; cyc++) begin
            if (cyc < 20) begin
                set_issue(ROB_REG, 5'(cyc % 31 + 1), 1'b1, 32'(cyc * 3 + 1), 1'b0, 32'd0);
                sb_q.push_back('{rd: 5'(cyc % 31 + 1), data: 32'(cyc * 3 + 1), entry: 3'(cyc % 8)});
            end else begin
                idle_inputs();
            end
            tick();
            if (rob_commit === 1'b1) begin
                started = 1'b1;
                n_commit++;
            end else if (started && n_commit < 20) begin
                gaps++;
            end
        end
        idle_inputs();
        checks++;
        if ({n_commit, gaps, sb_q.size()} !== {32'd20, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL wrap_stream: got commits=%0d gaps=%0d pending=%0d, expected 20 0 0",
                     n_commit, gaps, sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_commit();
        test_full_and_bypass();
        test_branch();
        test_store_exit();
        test_rdy_hold();
        test_back_to_back();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
